// File: rtl/fifo_flag_gen.sv
// Write-side occupancy tracker and registered AE/AF/EMPTY/FULL/overflow flag generator for the sample FIFO.
// Optional macro FLAG_HYST_EN adds HYST words of hysteresis to the AE/AF flags.
module fifo_flag_gen #(
  parameter int DEPTH       = 512,
  parameter int CNT_W       = 10,
  parameter int AE_THR      = 16,
  parameter int AF_THR      = 496,
  parameter int STOP_ON_OVF = 1,
  parameter int HYST        = 4
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             enable,
  input  logic             wr_req,
  input  logic             rd_strobe,
  input  logic             clr_ovf,
  output logic             WEN,
  output logic             AE,
  output logic             AF,
  output logic             EMPTY,
  output logic             FULL,
  output logic             ovf,
  output logic [CNT_W-1:0] level
);

`ifdef FLAG_HYST_EN
  localparam int HYST_EFF = HYST;
`else
  localparam int HYST_EFF = 0;
`endif

  localparam logic [CNT_W-1:0] DEPTH_L = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AE_LO_L = CNT_W'(AE_THR);
  localparam logic [CNT_W-1:0] AE_HI_L = CNT_W'(AE_THR + HYST_EFF);
  localparam logic [CNT_W-1:0] AF_HI_L = CNT_W'(AF_THR);
  localparam logic [CNT_W-1:0] AF_LO_L = CNT_W'(AF_THR - HYST_EFF);
  localparam logic [CNT_W-1:0] ONE_L   = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_HALT = 2'b10
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] level_q, level_d;
  logic             wen_q, wen_d;
  logic             ae_q, ae_d;
  logic             af_q, af_d;
  logic             empty_q, empty_d;
  logic             full_q, full_d;
  logic             ovf_q, ovf_d;

  logic run_s, rd_acc_s, wr_acc_s, drop_s;

  // Accept/drop decisions; enable low in RUN blocks the write without counting a drop.
  always_comb begin
    run_s    = (state_q == S_RUN) && enable;
    rd_acc_s = rd_strobe && (level_q != '0);
    wr_acc_s = run_s && wr_req && ((level_q != DEPTH_L) || rd_acc_s);
    drop_s   = run_s && wr_req && !wr_acc_s;
  end

  // Next-state, next-level and flag computation; all flags derive from level_d.
  always_comb begin
    state_d = state_q;
    level_d = level_q;
    wen_d   = wr_acc_s;
    ovf_d   = ovf_q;

    case (state_q)
      S_IDLE: begin
        if (enable) state_d = S_RUN;
        else        state_d = S_IDLE;
      end
      S_RUN: begin
        if (!enable)                              state_d = S_IDLE;
        else if (drop_s && (STOP_ON_OVF != 0))    state_d = S_HALT;
        else                                      state_d = S_RUN;
      end
      S_HALT: begin
        if (!enable) state_d = S_IDLE;
        else         state_d = S_HALT;
      end
      default: state_d = S_IDLE;
    endcase

    if (wr_acc_s && !rd_acc_s)      level_d = level_q + ONE_L;
    else if (rd_acc_s && !wr_acc_s) level_d = level_q - ONE_L;
    else                            level_d = level_q;

    // A drop wins over a simultaneous clear so no overflow event is lost.
    if (drop_s)       ovf_d = 1'b1;
    else if (clr_ovf) ovf_d = 1'b0;
    else              ovf_d = ovf_q;

    // With HYST_EFF == 0 both band edges coincide and these reduce to plain compares.
    if (ae_q) ae_d = (level_d <= AE_HI_L);
    else      ae_d = (level_d <= AE_LO_L);
    if (af_q) af_d = (level_d >= AF_LO_L);
    else      af_d = (level_d >= AF_HI_L);

    empty_d = (level_d == '0);
    full_d  = (level_d == DEPTH_L);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!Reset) begin
      state_q <= S_IDLE;
      level_q <= '0;
      wen_q   <= 1'b0;
      ae_q    <= 1'b1;
      af_q    <= 1'b0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      wen_q   <= wen_d;
      ae_q    <= ae_d;
      af_q    <= af_d;
      empty_q <= empty_d;
      full_q  <= full_d;
      ovf_q   <= ovf_d;
    end
  end

  assign WEN   = wen_q;
  assign AE    = ae_q;
  assign AF    = af_q;
  assign EMPTY = empty_q;
  assign FULL  = full_q;
  assign ovf   = ovf_q;
  assign level = level_q;

endmodule

// File: tb/tb_fifo_flag_gen.sv
// Self-checking bench for fifo_flag_gen: two instances (halt-on-overflow and keep-running)
// share stimulus and are checked every cycle against an occupancy model plus literal expectations.
module tb_fifo_flag_gen;
  localparam int DEPTH = 16;
  localparam int CW    = 5;
  localparam int AE_T  = 2;
  localparam int AF_T  = 13;
  localparam int HY    = 2;
`ifdef FLAG_HYST_EN
  localparam int HB   = HY;
  localparam int HYON = 1;
`else
  localparam int HB   = 0;
  localparam int HYON = 0;
`endif

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic Reset = 1'b0, enable = 1'b0, wr_req = 1'b0, rd_strobe = 1'b0, clr_ovf = 1'b0;
  logic [1:0] wen, ae, af, empty, full, ovf;
  logic [CW-1:0] lvl [2];

  fifo_flag_gen #(.DEPTH(DEPTH), .CNT_W(CW), .AE_THR(AE_T), .AF_THR(AF_T),
                  .STOP_ON_OVF(1), .HYST(HY)) u_halt (
    .CLK(CLK), .Reset(Reset), .enable(enable), .wr_req(wr_req), .rd_strobe(rd_strobe),
    .clr_ovf(clr_ovf), .WEN(wen[0]), .AE(ae[0]), .AF(af[0]), .EMPTY(empty[0]),
    .FULL(full[0]), .ovf(ovf[0]), .level(lvl[0]));

  fifo_flag_gen #(.DEPTH(DEPTH), .CNT_W(CW), .AE_THR(AE_T), .AF_THR(AF_T),
                  .STOP_ON_OVF(0), .HYST(HY)) u_run (
    .CLK(CLK), .Reset(Reset), .enable(enable), .wr_req(wr_req), .rd_strobe(rd_strobe),
    .clr_ovf(clr_ovf), .WEN(wen[1]), .AE(ae[1]), .AF(af[1]), .EMPTY(empty[1]),
    .FULL(full[1]), .ovf(ovf[1]), .level(lvl[1]));

  int vectors = 0;
  int miscompares = 0;

  // Model: mode 0 = idle, 1 = run, 2 = halted.
  int m_lvl [2];
  int m_mode [2];
  bit m_wen [2], m_ae [2], m_af [2], m_ovf [2];
  bit m_ok = 1'b0;

  always @(posedge CLK) begin
    for (int k = 0; k < 2; k++) begin
      bit rd_ok, wr_ok, drop;
      if (!Reset) begin
        m_lvl[k] = 0; m_mode[k] = 0; m_wen[k] = 0; m_ae[k] = 1; m_af[k] = 0; m_ovf[k] = 0;
      end else if (m_ok) begin
        rd_ok = rd_strobe && (m_lvl[k] > 0);
        wr_ok = (m_mode[k] == 1) && enable && wr_req && (m_lvl[k] < DEPTH || rd_ok);
        drop  = (m_mode[k] == 1) && enable && wr_req && !wr_ok;
        m_lvl[k] = m_lvl[k] + (wr_ok ? 1 : 0) - (rd_ok ? 1 : 0);
        m_wen[k] = wr_ok;
        if (drop) m_ovf[k] = 1;
        else if (clr_ovf) m_ovf[k] = 0;
        if (!enable) m_mode[k] = 0;
        else if (m_mode[k] == 0) m_mode[k] = 1;
        else if (m_mode[k] == 1 && drop && k == 0) m_mode[k] = 2;
        if (m_lvl[k] <= AE_T) m_ae[k] = 1;
        else if (m_lvl[k] > AE_T + HB) m_ae[k] = 0;
        if (m_lvl[k] >= AF_T) m_af[k] = 1;
        else if (m_lvl[k] < AF_T - HB) m_af[k] = 0;
      end
    end
    if (!Reset) m_ok = 1'b1;
    #1;
    if (m_ok) begin
      for (int k = 0; k < 2; k++) begin
        logic [5:0] act, exp;
        act = {wen[k], ae[k], af[k], empty[k], full[k], ovf[k]};
        exp = {m_wen[k], m_ae[k], m_af[k], m_lvl[k] == 0, m_lvl[k] == DEPTH, m_ovf[k]};
        vectors++;
        if (act !== exp || int'(lvl[k]) != m_lvl[k]) begin
          miscompares++;
          $display("FAIL model_inst%0d t=%0t: got {wen,ae,af,em,fu,ovf}=%b level=%0d, expected %b level=%0d",
                   k, $time, act, lvl[k], exp, m_lvl[k]);
        end
      end
    end
  end

  task automatic cyc(input bit r, input bit e, input bit w, input bit rd, input bit c);
    Reset = r; enable = e; wr_req = w; rd_strobe = rd; clr_ovf = c;
    @(negedge CLK);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  initial begin
    cyc(0, 0, 0, 0, 0);
    cyc(0, 1, 1, 0, 0);
    chk("rst_level", lvl[0], 0);  chk("rst_wen", wen[0], 0);  chk("rst_ae", ae[0], 1);
    chk("rst_af", af[0], 0);      chk("rst_empty", empty[0], 1); chk("rst_full", full[0], 0);
    chk("rst_ovf", ovf[0], 0);

    cyc(1, 1, 0, 0, 0);
    cyc(1, 1, 1, 0, 0); chk("w1_wen", wen[0], 1); chk("w1_level", lvl[0], 1);
    cyc(1, 1, 1, 0, 0); chk("w2_ae", ae[0], 1);
    cyc(1, 1, 1, 0, 0); chk("w3_ae", ae[0], HYON); chk("w3_empty", empty[0], 0);
    cyc(1, 1, 0, 0, 0); chk("idle_wen", wen[0], 0); chk("w3_level", lvl[0], 3);
    for (int i = 4; i <= 16; i++) begin
      cyc(1, 1, 1, 0, 0);
      if (i == 12) chk("af_at12_up", af[0], 0);
      if (i == 13) chk("af_at13_up", af[0], 1);
    end
    chk("full16", full[0], 1); chk("lvl16", lvl[0], 16);
    cyc(1, 1, 1, 0, 0); chk("w17_wen", wen[0], 0); chk("w17_ovf", ovf[0], 1); chk("w17_ovf_run", ovf[1], 1);
    cyc(1, 1, 1, 0, 0); chk("halt_wen", wen[0], 0);
    cyc(1, 1, 1, 1, 0); chk("halt_rd_lvl", lvl[0], 15); chk("halt_rd_wen", wen[0], 0);
    chk("run_wrrd_wen", wen[1], 1); chk("run_wrrd_lvl", lvl[1], 16);
    cyc(1, 0, 0, 0, 1); chk("clr_ovf", ovf[0], 0);
    cyc(1, 1, 0, 0, 0);
    cyc(1, 1, 1, 0, 0); chk("refill_lvl", lvl[0], 16);
    cyc(1, 1, 1, 1, 0); chk("full_wrrd_wen", wen[0], 1); chk("full_wrrd_lvl", lvl[0], 16);
    chk("full_wrrd_ovf", ovf[0], 0);
    cyc(1, 1, 1, 0, 1); chk("drop_beats_clr", ovf[0], 1);
    for (int i = 15; i >= 0; i--) begin
      cyc(1, 1, 0, 1, 0);
      if (i == 13) chk("af_at13_dn", af[0], 1);
      if (i == 12) chk("af_at12_dn", af[0], HYON);
      if (i == 11) chk("af_at11_dn", af[0], HYON);
      if (i == 10) chk("af_at10_dn", af[0], 0);
    end
    cyc(1, 1, 0, 1, 0); chk("under_lvl", lvl[0], 0); chk("under_empty", empty[0], 1);
    chk("under_ae", ae[0], 1);

    cyc(1, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0);
    for (int i = 0; i < 9; i++) cyc(1, 1, 1, 0, 0);
    chk("pre_rst_lvl", lvl[0], 9);
    cyc(0, 1, 1, 0, 0);
    chk("mid_rst_lvl", lvl[0], 0); chk("mid_rst_wen", wen[0], 0); chk("mid_rst_ae", ae[0], 1);
    chk("mid_rst_af", af[0], 0);   chk("mid_rst_ovf_run", ovf[1], 0);
    cyc(1, 1, 1, 0, 0); chk("post_rst_wen", wen[0], 0);
    cyc(1, 1, 1, 0, 0); chk("post_rst_run_wen", wen[0], 1); chk("post_rst_run_lvl", lvl[0], 1);
    cyc(1, 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/fifo_flag_gen.md
Name: fifo_flag_gen

Overview:
- Write-side companion to the FIFO flag receiver feeding the PIC.
- Accepts beam-scanner sample strobes and drives the write enable of the sample FIFO.
- Tracks FIFO occupancy from accepted writes and PIC read strobes.
- Generates registered almost-empty (AE) and almost-full (AF) flags plus full/empty/overflow status. The AE/AF edges are what the downstream read-request logic reacts to.

Parameters:
- DEPTH, 512, FIFO capacity in words.
- CNT_W, 10, occupancy counter width. Must satisfy 2^CNT_W > DEPTH.
- AE_THR, 16, AE asserted while level <= AE_THR.
- AF_THR, 496, AF asserted while level >= AF_THR. Must satisfy AE_THR < AF_THR.
- STOP_ON_OVF, 1, 1 = enter HALT on the first dropped sample; 0 = keep running and drop only.
- HYST, 4, flag hysteresis in words. Used only with FLAG_HYST_EN.

Ports:
- CLK  in  1  system clock; all logic on the rising edge.
- Reset  in  1  synchronous, active-low reset.
- enable  in  1  capture enable from the scan controller.
- wr_req  in  1  one-cycle strobe: sample valid at the ADC output.
- rd_strobe  in  1  one-cycle strobe: PIC popped one word.
- clr_ovf  in  1  one-cycle strobe: clears the overflow flag.
- WEN  out  1  FIFO write enable, registered.
- AE  out  1  almost-empty flag.
- AF  out  1  almost-full flag.
- EMPTY  out  1  high when level == 0.
- FULL  out  1  high when level == DEPTH.
- ovf  out  1  sticky flag: a sample was dropped.
- level  out  CNT_W  current occupancy.

Behaviour:
- Reset (Reset == 0 at a CLK edge) sets: state IDLE, level 0, WEN 0, AE 1, AF 0, EMPTY 1, FULL 0, ovf 0.
- Reset mid-burst discards the count. The FIFO itself is reset externally by the same signal.
- States:
  - IDLE -> RUN when enable == 1.
  - RUN -> IDLE when enable == 0.
  - RUN -> HALT when a sample is dropped and STOP_ON_OVF == 1.
  - HALT -> IDLE only when enable == 0. HALT ignores wr_req.
- Write accept (wa) = state RUN && wr_req && (level < DEPTH || rd_accept).
  - Writing while full is allowed when a read is accepted in the same cycle.
- Read accept (ra) = rd_strobe && level > 0.
  - A read when empty is ignored, with no underflow wrap.
  - Reads are honoured in every state, so IDLE and HALT still drain.
- Drop = state RUN && wr_req && !wa. A drop sets ovf.
- ovf clear priority: a drop and clr_ovf in the same cycle leave ovf = 1.
- Level update on every edge:
  - +1 if wa && !ra.
  - -1 if ra && !wa.
  - Unchanged if both or neither.
  - Level never exceeds DEPTH and never goes below 0.
- Latency:
  - WEN is high for exactly one cycle, the cycle after the edge where wa was sampled. It is 1:1 with accepted writes.
  - level, AE, AF, EMPTY and FULL are all computed from the next-level value and registered on the same edge as WEN. All outputs are therefore mutually consistent in every cycle.
- Flags (no hysteresis):
  - AE = (level <= AE_THR).
  - AF = (level >= AF_THR).
  - EMPTY and FULL are exact compares.
- Leaving RUN takes effect on the edge where enable is sampled low. A wr_req in that same cycle is not written and does not count as a drop.
- Back-to-back wr_req every cycle is supported at full rate.

Optional Feature:
- Macro: FLAG_HYST_EN.
- Defined:
  - AE asserts when level <= AE_THR and deasserts only when level > AE_THR + HYST.
  - AF asserts when level >= AF_THR and deasserts only when level < AF_THR - HYST.
  - Each flag holds its value inside the hysteresis band. This suppresses edge chatter toward the PIC.
  - Reset values are unchanged.
- Undefined: pure threshold compares as in Behaviour; the HYST parameter is unused.

Test Plan (DEPTH=16, AE_THR=2, AF_THR=13, HYST=2 unless stated):
- Reset, then enable=1 with 3 wr_req -> 3 WEN pulses, each 1 cycle after its strobe. level=3, AE falls in the cycle level goes 2->3, EMPTY=0.
- 13 writes from empty -> AF rises in the same cycle level==13. After 16 writes FULL=1. A 17th wr_req gives no WEN and ovf=1, and the state is HALT. Further wr_req produce no WEN until enable toggles low.
- At level=16, wr_req and rd_strobe in the same cycle -> WEN pulses, level stays 16, no ovf.
- At level=0, rd_strobe -> level stays 0, EMPTY=1, AE=1. With STOP_ON_OVF=0, overflowing while full -> ovf=1, the state stays RUN, and writes resume after reads.
- Reset asserted low at level=9 during a write burst -> next cycle level=0, WEN=0, AE=1, AF=0, ovf=0, IDLE; no WEN is issued for the in-flight request.
- FLAG_HYST_EN: level moves 13->12->11->10 -> AF stays 1 at 12 and 11 and falls at 10. Without the macro, AF falls at 12.
